fib_seq_gen: RTL and testbench

Parametrised successor to the single-mode Fibonacci engine. It computes term n of a selectable integer recurrence: Fibonacci, Lucas, custom-seed order-2, or Tribonacci. It uses the same go/done handshake, produces one term per clock, tracks exact overflow per term, and optionally saturates the result. It sits behind the existing handshake BFM, so the current done/go/result/overflow assertions apply unchanged.

---
 rtl/fib_seq_gen.sv | 171 +++++++++++++++++
 tb/tb_fib_seq_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_gen.sv
// fib_seq_gen -- computes term n of a selectable integer recurrence, one
// new term per clock, with exact per-term overflow tracking.
//
// Handshake: a request is accepted when go=1 at a rising edge while the block
// is IDLE or DONE. Acceptance clears done and latches n, mode and the seeds.
// The block then computes, waits for go to drop, and raises done together
// with result/overflow. Those outputs are held until the next accepted go
// clears done. go is ignored while busy.
//
// Parameters:
//   INPUT_WIDTH  - width of n
//   OUTPUT_WIDTH - width of result, seed0, seed1
//   SATURATE     - 0: result wraps on overflow; 1: result is all-ones on overflow
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous reset, active low
//   go       - start request, level-sampled
//   n        - index of the requested term
//   mode     - 00 Fibonacci, 01 Lucas, 10 custom seeds, 11 Tribonacci
//   seed0    - T(0) for custom mode
//   seed1    - T(1) for custom mode
//   result   - T(n), wrapped or saturated
//   overflow - some term T(2..n) did not fit in OUTPUT_WIDTH bits
//   done     - result/overflow valid
//   busy     - computation in progress (COMPUTE or FINISH)
module fib_seq_gen #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32,
    parameter int SATURATE     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic [INPUT_WIDTH-1:0]  n,
    input  logic [1:0]              mode,
    input  logic [OUTPUT_WIDTH-1:0] seed0,
    input  logic [OUTPUT_WIDTH-1:0] seed1,
    output logic [OUTPUT_WIDTH-1:0] result,
    output logic                    overflow,
    output logic                    done,
    output logic                    busy
);

    localparam int W = OUTPUT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_FINISH  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Sliding window of the three most recent terms: x0 is the oldest.
    // Each term carries its own flag, which is the OR of its own carry and
    // the flags of its ancestors, so terms past index n never leak into
    // the reported overflow.
    logic [W-1:0]           x0, x1, x2;
    logic                   f0, f1, f2;
    logic [INPUT_WIDTH-1:0] cnt;
    logic                   trib_q;

    logic                   accept;
    logic [W:0]             sum2;
    logic [W+1:0]           sum3;
    logic [W-1:0]           new_term;
    logic                   new_flag;
    logic [W-1:0]           init0, init1, init2;

    // Next-state logic and status outputs.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (go) begin
                    accept    = 1'b1;
                    state_nxt = (n != '0) ? S_COMPUTE : S_FINISH;
                end
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (cnt == INPUT_WIDTH'(1)) state_nxt = S_FINISH;
            end
            S_FINISH: begin
                busy = 1'b1;
                // A held go keeps us here, so done never rises right after go=1.
                if (!go) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Seed values chosen by the requested mode.
    always_comb begin
        init0 = '0;
        init1 = W'(1);
        init2 = '0;
        case (mode)
            2'b00: begin init0 = '0;      init1 = W'(1); end
            2'b01: begin init0 = W'(2);   init1 = W'(1); end
            2'b10: begin init0 = seed0;   init1 = seed1; end
            2'b11: begin init0 = '0;      init1 = '0;    init2 = W'(1); end
            default: ;
        endcase
    end

    // Next term and its flag. Tribonacci needs two guard bits for a 3-way sum.
    always_comb begin
        sum2 = {1'b0, x0} + {1'b0, x1};
        sum3 = {2'b00, x0} + {2'b00, x1} + {2'b00, x2};
        if (trib_q) begin
            new_term = sum3[W-1:0];
            new_flag = (sum3[W+1:W] != 2'b00) | f0 | f1 | f2;
        end else begin
            new_term = sum2[W-1:0];
            new_flag = sum2[W] | f0 | f1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            x0       <= '0;
            x1       <= '0;
            x2       <= '0;
            f0       <= 1'b0;
            f1       <= 1'b0;
            f2       <= 1'b0;
            cnt      <= '0;
            trib_q   <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                x0     <= init0;
                x1     <= init1;
                x2     <= init2;
                f0     <= 1'b0;
                f1     <= 1'b0;
                f2     <= 1'b0;
                cnt    <= n;
                trib_q <= (mode == 2'b11);
                done   <= 1'b0;
            end else if (state == S_COMPUTE) begin
                x0  <= x1;
                f0  <= f1;
                cnt <= cnt - INPUT_WIDTH'(1);
                if (trib_q) begin
                    x1 <= x2;
                    f1 <= f2;
                    x2 <= new_term;
                    f2 <= new_flag;
                end else begin
                    x1 <= new_term;
                    f1 <= new_flag;
                end
            end else if (state == S_FINISH && !go) begin
                result   <= ((SATURATE != 0) && f0) ? '1 : x0;
                overflow <= f0;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fib_seq_gen.sv
module tb_fib_seq_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [5:0]  n;
    logic [1:0]  mode;
    logic [31:0] seed0, seed1;
    logic [31:0] result, result_s;
    logic        overflow, overflow_s;
    logic        done, done_s;
    logic        busy, busy_s;

    int vectors = 0;
    int errors  = 0;
    logic [32:0] exp_q[$];

    fib_seq_gen #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(32), .SATURATE(0)) dut (
        .clk(clk), .rst(rst), .go(go), .n(n), .mode(mode),
        .seed0(seed0), .seed1(seed1),
        .result(result), .overflow(overflow), .done(done), .busy(busy)
    );

    fib_seq_gen #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(32), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .go(go), .n(n), .mode(mode),
        .seed0(seed0), .seed1(seed1),
        .result(result_s), .overflow(overflow_s), .done(done_s), .busy(busy_s)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Driver: single-cycle go pulse, inputs applied on the falling edge.
    task automatic start(input logic [5:0] tn, input logic [1:0] tm,
                         input logic [31:0] s0, input logic [31:0] s1);
        @(negedge clk);
        n = tn; mode = tm; seed0 = s0; seed1 = s1; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // Counts falling edges from the one after the accepting edge until done.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 300) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) check("done_timeout", done, 1);
    endtask

    task automatic run(input string tag, input logic [5:0] tn, input logic [1:0] tm,
                       input logic [31:0] s0, input logic [31:0] s1,
                       input logic [31:0] exp_r, input logic exp_o);
        int lat, bcnt;
        start(tn, tm, s0, s1);
        wait_done(lat, bcnt);
        check({tag, "_result"}, result, exp_r);
        check({tag, "_ovf"}, overflow, exp_o);
    endtask

    // Reference model: exact sticky overflow over T(2..n), wrapped value.
    function automatic logic [32:0] model(input int tn, input logic [1:0] tm,
                                          input logic [31:0] s0, input logic [31:0] s1);
        logic [33:0] a, b, c, t;
        logic ov;
        ov = 1'b0;
        if (tm == 2'b11) begin
            a = 0; b = 0; c = 1;
            if (tn < 2) return 33'd0;
            for (int k = 3; k <= tn; k++) begin
                t = a + b + c;
                if (t[33:32] != 2'b00) ov = 1'b1;
                a = b; b = c; c = {2'b00, t[31:0]};
            end
            return {ov, c[31:0]};
        end
        case (tm)
            2'b00:   begin a = 0;  b = 1;  end
            2'b01:   begin a = 2;  b = 1;  end
            default: begin a = {2'b00, s0}; b = {2'b00, s1}; end
        endcase
        if (tn == 0) return {1'b0, a[31:0]};
        for (int k = 2; k <= tn; k++) begin
            t = a + b;
            if (t[33:32] != 2'b00) ov = 1'b1;
            a = b; b = {2'b00, t[31:0]};
        end
        return {ov, b[31:0]};
    endfunction

    initial begin
        int lat, bcnt, early, changes;
        logic [31:0] r0;
        logic o0;
        logic [32:0] e;
        logic [5:0] tn;
        logic [1:0] tm;
        logic [31:0] s0, s1;

        rst = 1'b0; go = 1'b0; n = '0; mode = '0; seed0 = '0; seed1 = '0;
        repeat (3) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_ovf", overflow, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;

        // Fibonacci n=10 with latency and busy duration
        start(6'd10, 2'b00, 0, 0);
        wait_done(lat, bcnt);
        check("fib10_latency", lat, 11);
        check("fib10_busy_cycles", bcnt, 11);
        check("fib10_result", result, 55);
        check("fib10_ovf", overflow, 0);
        check("fib10_sat_result", result_s, 55);

        run("fib47", 6'd47, 2'b00, 0, 0, 32'd2971215073, 1'b0);
        run("fib48", 6'd48, 2'b00, 0, 0, 32'd512559680, 1'b1);
        check("fib48_sat_result", result_s, 32'hFFFF_FFFF);
        check("fib48_sat_ovf", overflow_s, 1);

        start(6'd63, 2'b00, 0, 0);
        wait_done(lat, bcnt);
        check("fib63_latency", lat, 64);
        check("fib63_result", result, 32'd3350226146);
        check("fib63_ovf", overflow, 1);

        start(6'd0, 2'b01, 0, 0);
        wait_done(lat, bcnt);
        check("lucas0_latency", lat, 1);
        check("lucas0_result", result, 2);
        check("lucas0_ovf", overflow, 0);

        run("lucas10", 6'd10, 2'b01, 0, 0, 32'd123, 1'b0);
        run("custom5", 6'd5, 2'b10, 32'd3, 32'd4, 32'd29, 1'b0);
        run("custom0", 6'd0, 2'b10, 32'hDEAD_BEEF, 32'd7, 32'hDEAD_BEEF, 1'b0);
        run("custom1_big", 6'd1, 2'b10, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        run("custom2_ovf", 6'd2, 2'b10, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        check("custom2_sat_result", result_s, 32'hFFFF_FFFF);
        run("trib7", 6'd7, 2'b11, 0, 0, 32'd13, 1'b0);
        run("trib2", 6'd2, 2'b11, 0, 0, 32'd1, 1'b0);

        // go held high for 20 edges: done waits for the first edge with go=0
        @(negedge clk);
        n = 6'd3; mode = 2'b00; go = 1'b1;
        early = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) early++;
        end
        check("held_go_done_low", early, 0);
        go = 1'b0;
        @(negedge clk);
        check("held_go_done", done, 1);
        check("held_go_result", result, 2);

        // go pulse during COMPUTE is ignored
        start(6'd20, 2'b00, 0, 0);
        repeat (5) @(negedge clk);
        n = 6'd5; mode = 2'b01; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done(lat, bcnt);
        check("ignore_go_result", result, 6765);
        check("ignore_go_ovf", overflow, 0);

        // go in DONE: done drops next cycle, old result held
        @(negedge clk);
        n = 6'd10; mode = 2'b00; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("redo_done_low", done, 0);
        check("redo_old_result", result, 6765);
        wait_done(lat, bcnt);
        check("redo_result", result, 55);

        // Stability in DONE
        r0 = result; o0 = overflow; changes = 0;
        repeat (50) begin
            @(negedge clk);
            if (result !== r0 || overflow !== o0 || done !== 1'b1) changes++;
        end
        check("done_stable", changes, 0);

        // Asynchronous reset mid-COMPUTE
        start(6'd40, 2'b00, 0, 0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_result", result, 0);
        check("midrst_ovf", overflow, 0);
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        run("post_rst_fib5", 6'd5, 2'b00, 0, 0, 32'd5, 1'b0);

        // Randomised runs against the reference model
        for (int i = 0; i < 40; i++) begin
            tn = 6'($urandom_range(0, 63));
            tm = 2'($urandom_range(0, 3));
            s0 = $urandom;
            s1 = $urandom;
            exp_q.push_back(model(int'(tn), tm, s0, s1));
            start(tn, tm, s0, s1);
            wait_done(lat, bcnt);
            e = exp_q.pop_front();
            check("rand_latency", lat, int'(tn) + 1);
            check("rand_result", result, e[31:0]);
            check("rand_ovf", overflow, e[32]);
            check("rand_sat_result", result_s, e[32] ? 32'hFFFF_FFFF : e[31:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
